apb_master_req: RTL and testbench
=================================

Name: apb_master_req

Overview:
APB3 requester that drives the bus on behalf of a local command source and collects the completer's response. It sits between the local control path and the register completers on the PCLK domain. Each accepted command becomes exactly one APB SETUP/ACCESS transfer. The block returns exactly one response pulse per accepted command, carrying read data, a slave-error flag and a timeout flag.

Parameters:
DWIDTH, 8, data width of PWDATA/PRDATA and the command/response data paths
AWIDTH, 8, width of PADDR/cmd_addr
NSLV, 5, number of completers; width of the one-hot PSEL vector
TMO_CYC, 16, maximum ACCESS cycles with PREADY low before abort; 0 disables timeout; legal range 0..255

Ports:
PCLK  in  1  bus clock; all logic on rising edge
PRESETn  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accept; high only in IDLE
cmd_write  in  1  1 = write, 0 = read
cmd_sel  in  NSLV  one-hot target completer select
cmd_addr  in  AWIDTH  transfer address
cmd_wdata  in  DWIDTH  write data
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DWIDTH  read data; 0 for writes, errors and timeouts
rsp_err  out  1  PSLVERR, illegal select, or timeout
rsp_tmo  out  1  timeout abort
PSEL  out  NSLV  one-hot completer select
PENABLE  out  1  ACCESS phase
PWRITE  out  1  transfer direction
PADDR  out  AWIDTH  address
PWDATA  out  DWIDTH  write data
PRDATA  in  DWIDTH  read data from selected completer
PREADY  in  1  completer ready
PSLVERR  in  1  completer error

Behaviour:
- Reset (PRESETn low, asynchronous): state = IDLE.
  - PSEL = 0, PENABLE = 0, PWRITE = 0, PADDR = 0, PWDATA = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, rsp_tmo = 0, wait counter = 0.
  - All inputs are ignored while PRESETn is low.
- State machine: IDLE, SETUP, ACCESS.
  - cmd_ready = (state == IDLE), combinational from the state.
- IDLE: a handshake occurs on a rising edge with cmd_valid && cmd_ready.
  - Capture cmd_write/cmd_addr/cmd_wdata into PWRITE/PADDR/PWDATA.
  - If cmd_sel is one-hot: PSEL = cmd_sel and go to SETUP.
  - If cmd_sel is zero or has more than one bit set: no bus activity, stay in IDLE. Next cycle rsp_valid = 1, rsp_err = 1, rsp_tmo = 0, rsp_rdata = 0.
- SETUP: PSEL asserted and PENABLE = 0 for exactly one cycle, then go to ACCESS with PENABLE = 1 and the wait counter cleared.
- ACCESS: PSEL, PWRITE, PADDR and PWDATA are held stable. PREADY is sampled on each rising edge.
  - PREADY = 1: go to IDLE with PSEL = 0 and PENABLE = 0. In the following cycle rsp_valid = 1, rsp_err = PSLVERR, rsp_tmo = 0, and rsp_rdata = PRDATA for a read (0 for a write, or when PSLVERR = 1).
  - PREADY = 0: increment the wait counter. If TMO_CYC != 0 and the counter reaches TMO_CYC, abort: go to IDLE with PSEL = 0 and PENABLE = 0, and respond with rsp_err = 1, rsp_tmo = 1, rsp_rdata = 0.
- Latency and throughput:
  - With zero wait states, the response pulse arrives 3 cycles after the accept edge.
  - A new command may be accepted in the same cycle that rsp_valid is high, giving back-to-back transfers every 3 cycles.
  - rsp_* fields hold their values after the pulse until the next response. rsp_valid is high for exactly one cycle per accepted command.
- PADDR/PWDATA/PWRITE keep their last values in IDLE and do not return to 0.
- Reset mid-transfer: PSEL and PENABLE drop immediately. No response is issued for the aborted command.
- Simultaneous PREADY = 1 and timeout threshold on the same edge: PREADY wins and the transfer completes normally.

Test Plan:
- Zero-wait write, then read-back: write sel=00001, addr=0x03, data=0xA5 with PREADY tied 1.
  - Required: SETUP then ACCESS, one cycle each; rsp_valid 3 cycles after accept, err=0.
  - Then read the same address with PRDATA=0xA5: rsp_rdata=0xA5.
- Wait states: read sel=00100 with PREADY low for 4 ACCESS cycles, PRDATA=0x3C.
  - Required: PENABLE high for 5 cycles, address and select stable throughout; rsp_rdata=0x3C, err=0.
- Slave error: write with PSLVERR=1 and PREADY=1.
  - Required: rsp_err=1, rsp_tmo=0, rsp_rdata=0.
- Timeout: TMO_CYC=16, PREADY stuck low.
  - Required: abort after 16 ACCESS cycles, PSEL returns to 0, rsp_err=1, rsp_tmo=1.
  - A subsequent command completes normally.
- Illegal select: cmd_sel=00000, and separately cmd_sel=00011.
  - Required: PSEL never asserted; rsp_valid next cycle with err=1.
- Back-to-back and reset: cmd_valid held high across 3 commands.
  - Required: accepts exactly 3 cycles apart and 3 responses.
  - Asserting PRESETn low during ACCESS clears PSEL/PENABLE immediately, and no rsp_valid is issued.

Source files
------------

// File: rtl/apb_master_req.sv
// APB3 requester: turns each accepted local command into one SETUP/ACCESS
// transfer and returns a single response pulse (read data, slave error, timeout).
module apb_master_req #(
    parameter int unsigned DWIDTH  = 8,
    parameter int unsigned AWIDTH  = 8,
    parameter int unsigned NSLV    = 5,
    parameter int unsigned TMO_CYC = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [NSLV-1:0]   cmd_sel,
    input  logic [AWIDTH-1:0] cmd_addr,
    input  logic [DWIDTH-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_tmo,
    output logic [NSLV-1:0]   PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [AWIDTH-1:0] PADDR,
    output logic [DWIDTH-1:0] PWDATA,
    input  logic [DWIDTH-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [CW-1:0]     wait_cnt, wait_cnt_n, wait_inc;
    logic [NSLV-1:0]   psel_n;
    logic              penable_n, pwrite_n;
    logic [AWIDTH-1:0] paddr_n;
    logic [DWIDTH-1:0] pwdata_n;
    logic              rsp_valid_n, rsp_err_n, rsp_tmo_n;
    logic [DWIDTH-1:0] rsp_rdata_n;
    logic              sel_onehot;
    logic              tmo_hit;

    assign cmd_ready  = (state == IDLE);
    assign sel_onehot = (cmd_sel != '0) && ((cmd_sel & (cmd_sel - NSLV'(1))) == '0);
    assign wait_inc   = wait_cnt + CW'(1);
    assign tmo_hit    = (TMO_CYC != 0) && (wait_inc == CW'(TMO_CYC));

    // Next-state and next-output logic; registered outputs hold by default.
    always_comb begin
        state_n     = state;
        wait_cnt_n  = wait_cnt;
        psel_n      = PSEL;
        penable_n   = PENABLE;
        pwrite_n    = PWRITE;
        paddr_n     = PADDR;
        pwdata_n    = PWDATA;
        rsp_valid_n = 1'b0;
        rsp_rdata_n = rsp_rdata;
        rsp_err_n   = rsp_err;
        rsp_tmo_n   = rsp_tmo;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    pwrite_n = cmd_write;
                    paddr_n  = cmd_addr;
                    pwdata_n = cmd_wdata;
                    if (sel_onehot) begin
                        psel_n  = cmd_sel;
                        state_n = SETUP;
                    end else begin
                        // Bad select is answered locally without touching the bus.
                        rsp_valid_n = 1'b1;
                        rsp_err_n   = 1'b1;
                        rsp_tmo_n   = 1'b0;
                        rsp_rdata_n = '0;
                    end
                end
            end
            SETUP: begin
                penable_n  = 1'b1;
                wait_cnt_n = '0;
                state_n    = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    state_n     = IDLE;
                    psel_n      = '0;
                    penable_n   = 1'b0;
                    rsp_valid_n = 1'b1;
                    rsp_err_n   = PSLVERR;
                    rsp_tmo_n   = 1'b0;
                    rsp_rdata_n = (!PWRITE && !PSLVERR) ? PRDATA : '0;
                end else begin
                    wait_cnt_n = wait_inc;
                    if (tmo_hit) begin
                        state_n     = IDLE;
                        psel_n      = '0;
                        penable_n   = 1'b0;
                        rsp_valid_n = 1'b1;
                        rsp_err_n   = 1'b1;
                        rsp_tmo_n   = 1'b1;
                        rsp_rdata_n = '0;
                    end
                end
            end
            default: begin
                state_n   = IDLE;
                psel_n    = '0;
                penable_n = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            rsp_tmo   <= 1'b0;
        end else begin
            state     <= state_n;
            wait_cnt  <= wait_cnt_n;
            PSEL      <= psel_n;
            PENABLE   <= penable_n;
            PWRITE    <= pwrite_n;
            PADDR     <= paddr_n;
            PWDATA    <= pwdata_n;
            rsp_valid <= rsp_valid_n;
            rsp_rdata <= rsp_rdata_n;
            rsp_err   <= rsp_err_n;
            rsp_tmo   <= rsp_tmo_n;
        end
    end

endmodule

// File: tb/tb_apb_master_req.sv
// Bench for apb_master_req: directed and randomized commands against a
// transaction-level expectation model and a reactive APB completer.
module tb_apb_master_req;

    localparam int unsigned DW  = 8;
    localparam int unsigned AW  = 8;
    localparam int unsigned NS  = 5;
    localparam int unsigned TMO = 16;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [NS-1:0] cmd_sel;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_err, rsp_tmo;
    logic [DW-1:0] rsp_rdata;
    logic [NS-1:0] PSEL;
    logic          PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA, PRDATA;
    logic          PREADY, PSLVERR;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       ready;
        logic       stable;
        logic [7:0] lat;
        logic [7:0] acc;
        logic [7:0] setup;
        logic       err;
        logic       tmo;
        logic [7:0] rdata;
    } obs_t;

    apb_master_req #(.DWIDTH(DW), .AWIDTH(AW), .NSLV(NS), .TMO_CYC(TMO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_tmo(rsp_tmo),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    // Expected outcome of one command, from the transfer rules alone.
    function automatic obs_t model(input logic wr, input logic [NS-1:0] sel,
                                   input logic [DW-1:0] rdata, input logic slverr,
                                   input int waits);
        obs_t e;
        e = '0;
        e.ready  = 1'b1;
        e.stable = 1'b1;
        if ($countones(sel) != 1) begin
            e.lat = 8'd1;
            e.err = 1'b1;
        end else if (TMO != 0 && waits >= int'(TMO)) begin
            e.lat   = 8'(2 + TMO);
            e.acc   = 8'(TMO);
            e.setup = 8'd1;
            e.err   = 1'b1;
            e.tmo   = 1'b1;
        end else begin
            e.lat   = 8'(3 + waits);
            e.acc   = 8'(waits + 1);
            e.setup = 8'd1;
            e.err   = slverr;
            e.rdata = (wr || slverr) ? 8'h00 : rdata;
        end
        return e;
    endfunction

    task automatic show(input string nm, input obs_t o, input obs_t e);
        $display("FAIL %s: got rdy=%0b stb=%0b lat=%0d acc=%0d setup=%0d err=%0b tmo=%0b rdata=%02h ; want rdy=%0b stb=%0b lat=%0d acc=%0d setup=%0d err=%0b tmo=%0b rdata=%02h",
                 nm, o.ready, o.stable, o.lat, o.acc, o.setup, o.err, o.tmo, o.rdata,
                 e.ready, e.stable, e.lat, e.acc, e.setup, e.err, e.tmo, e.rdata);
    endtask

    // Issues one command from a negedge and plays the completer until the response.
    task automatic run_txn(input logic wr, input logic [NS-1:0] sel, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                           input logic slverr, input int waits, output obs_t o);
        int  acc;
        int  n;
        logic legal;
        o      = '0;
        o.stable = 1'b1;
        acc    = 0;
        legal  = ($countones(sel) == 1);
        o.ready   = cmd_ready;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_sel   = sel;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        PRDATA    = rdata;
        PSLVERR   = slverr;
        PREADY    = 1'b0;
        for (n = 1; n <= 300; n++) begin
            @(negedge PCLK);
            cmd_valid = 1'b0;
            if (PSEL != '0) begin
                if (PENABLE) acc++;
                else o.setup = o.setup + 8'd1;
                if (!legal || PSEL != sel || PADDR != addr || PWRITE != wr || PWDATA != wdata)
                    o.stable = 1'b0;
            end
            if (rsp_valid) begin
                if (PSEL != '0 || PENABLE) o.stable = 1'b0;
                o.lat   = 8'(n);
                o.err   = rsp_err;
                o.tmo   = rsp_tmo;
                o.rdata = rsp_rdata;
                break;
            end
            PREADY = (PSEL != '0) && PENABLE && (acc > waits);
        end
        o.acc  = 8'(acc);
        PREADY = 1'b0;
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_sel = 5'b00001;
        cmd_addr = 8'hFF; cmd_wdata = 8'hFF;
        PRDATA = 8'hFF; PREADY = 1'b1; PSLVERR = 1'b1;
        repeat (3) @(negedge PCLK);
        total++;
        if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== '0) begin
            bad++;
            $display("FAIL reset_bus: got psel=%b pen=%b pwr=%b paddr=%h pwdata=%h want all 0",
                     PSEL, PENABLE, PWRITE, PADDR, PWDATA);
        end
        total++;
        if ({rsp_valid, rsp_err, rsp_tmo, rsp_rdata} !== '0) begin
            bad++;
            $display("FAIL reset_rsp: got v=%b err=%b tmo=%b rdata=%h want all 0",
                     rsp_valid, rsp_err, rsp_tmo, rsp_rdata);
        end
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: got %b want 1", cmd_ready);
        end
        cmd_valid = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0;
        PRESETn = 1'b1;
        @(negedge PCLK);
    endtask

    task automatic test_write_read();
        obs_t o, e;
        run_txn(1'b1, 5'b00001, 8'h03, 8'hA5, 8'h00, 1'b0, 0, o);
        e = model(1'b1, 5'b00001, 8'h00, 1'b0, 0);
        total++;
        if (o !== e) begin bad++; show("zero_wait_write", o, e); end
        run_txn(1'b0, 5'b00001, 8'h03, 8'h00, 8'hA5, 1'b0, 0, o);
        e = model(1'b0, 5'b00001, 8'hA5, 1'b0, 0);
        total++;
        if (o !== e) begin bad++; show("zero_wait_read", o, e); end
    endtask

    task automatic test_wait_states();
        obs_t o, e;
        run_txn(1'b0, 5'b00100, 8'h41, 8'h00, 8'h3C, 1'b0, 4, o);
        e = model(1'b0, 5'b00100, 8'h3C, 1'b0, 4);
        total++;
        if (o !== e) begin bad++; show("wait_states_read", o, e); end
    endtask

    task automatic test_slave_err();
        obs_t o, e;
        run_txn(1'b1, 5'b01000, 8'h77, 8'h5A, 8'hEE, 1'b1, 0, o);
        e = model(1'b1, 5'b01000, 8'hEE, 1'b1, 0);
        total++;
        if (o !== e) begin bad++; show("slave_err_write", o, e); end
        @(negedge PCLK);
        total++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b1 || PADDR !== 8'h77 || PWRITE !== 1'b1) begin
            bad++;
            $display("FAIL rsp_hold_idle: got v=%b err=%b paddr=%h pwrite=%b want v=0 err=1 paddr=77 pwrite=1",
                     rsp_valid, rsp_err, PADDR, PWRITE);
        end
    endtask

    task automatic test_timeout();
        obs_t o, e;
        run_txn(1'b0, 5'b10000, 8'h12, 8'h00, 8'h99, 1'b0, 1000, o);
        e = model(1'b0, 5'b10000, 8'h99, 1'b0, 1000);
        total++;
        if (o !== e) begin bad++; show("timeout_abort", o, e); end
        run_txn(1'b0, 5'b10000, 8'h13, 8'h00, 8'h66, 1'b0, 1, o);
        e = model(1'b0, 5'b10000, 8'h66, 1'b0, 1);
        total++;
        if (o !== e) begin bad++; show("after_timeout", o, e); end
        // PREADY arriving in the very cycle the timeout would fire.
        run_txn(1'b0, 5'b00010, 8'h14, 8'h00, 8'hC3, 1'b0, int'(TMO) - 1, o);
        e = model(1'b0, 5'b00010, 8'hC3, 1'b0, int'(TMO) - 1);
        total++;
        if (o !== e) begin bad++; show("pready_beats_timeout", o, e); end
    endtask

    task automatic test_illegal_sel();
        obs_t o, e;
        run_txn(1'b1, 5'b00000, 8'h20, 8'h11, 8'h22, 1'b0, 0, o);
        e = model(1'b1, 5'b00000, 8'h22, 1'b0, 0);
        total++;
        if (o !== e) begin bad++; show("illegal_sel_zero", o, e); end
        run_txn(1'b0, 5'b00011, 8'h21, 8'h11, 8'h22, 1'b0, 0, o);
        e = model(1'b0, 5'b00011, 8'h22, 1'b0, 0);
        total++;
        if (o !== e) begin bad++; show("illegal_sel_multi", o, e); end
    endtask

    task automatic test_back_to_back();
        int at [3];
        int na;
        int good_rsp;
        at = '{0, 0, 0};
        na = 0;
        good_rsp = 0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_sel = 5'b00010;
        cmd_addr = 8'h50; cmd_wdata = 8'h01;
        PREADY = 1'b1; PSLVERR = 1'b0;
        for (int n = 0; n < 15; n++) begin
            if (rsp_valid && !rsp_err && !rsp_tmo) good_rsp++;
            if (cmd_valid && cmd_ready) begin
                if (na < 3) at[na] = n;
                na++;
            end
            @(negedge PCLK);
            if (na >= 3) cmd_valid = 1'b0;
            else begin
                cmd_addr  = 8'($urandom);
                cmd_wdata = 8'($urandom);
            end
        end
        PREADY = 1'b0;
        total++;
        if (na != 3 || at[1] - at[0] != 3 || at[2] - at[1] != 3) begin
            bad++;
            $display("FAIL b2b_accepts: got n=%0d at=%0d,%0d,%0d want n=3 spaced by 3",
                     na, at[0], at[1], at[2]);
        end
        total++;
        if (good_rsp != 3) begin
            bad++;
            $display("FAIL b2b_responses: got %0d want 3", good_rsp);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int stray;
        obs_t o, e;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_sel = 5'b00010;
        cmd_addr = 8'h33; cmd_wdata = 8'h00; PREADY = 1'b0;
        for (n = 0; n < 10; n++) begin
            @(negedge PCLK);
            cmd_valid = 1'b0;
            if (PSEL != '0 && PENABLE) break;
        end
        #2 PRESETn = 1'b0;
        #1;
        total++;
        if (PSEL !== '0 || PENABLE !== 1'b0 || rsp_valid !== 1'b0 || n >= 10) begin
            bad++;
            $display("FAIL reset_mid_access: got psel=%b pen=%b v=%b reached=%0d want psel=0 pen=0 v=0",
                     PSEL, PENABLE, rsp_valid, n < 10);
        end
        @(negedge PCLK);
        PRESETn = 1'b1;
        stray = 0;
        repeat (20) begin
            @(negedge PCLK);
            if (rsp_valid || PSEL != '0) stray++;
        end
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL reset_no_rsp: got %0d stray cycles want 0", stray);
        end
        run_txn(1'b0, 5'b00010, 8'h34, 8'h00, 8'h7E, 1'b0, 2, o);
        e = model(1'b0, 5'b00010, 8'h7E, 1'b0, 2);
        total++;
        if (o !== e) begin bad++; show("after_reset_txn", o, e); end
    endtask

    task automatic test_random();
        obs_t o, e;
        logic wr, se;
        logic [NS-1:0] sel;
        logic [7:0] a, wd, rd;
        int waits, r;
        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom);
            se = ($urandom_range(0, 4) == 0);
            sel = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'(1 << $urandom_range(0, 4));
            a  = 8'($urandom);
            wd = 8'($urandom);
            rd = 8'($urandom);
            r  = int'($urandom_range(0, 9));
            waits = (r == 9) ? int'(TMO) + int'($urandom_range(0, 4)) : r;
            run_txn(wr, sel, a, wd, rd, se, waits, o);
            e = model(wr, sel, rd, se, waits);
            total++;
            if (o !== e) begin bad++; show($sformatf("random_%0d", i), o, e); end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_wait_states();
        test_slave_err();
        test_timeout();
        test_illegal_sel();
        test_back_to_back();
        repeat (2) @(negedge PCLK);
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
